// File: rtl/vga_frame_monitor.sv
// TinyVGA Pmod receiver: recovers pixel timing from sync edges,
// checks the sync periods and reports a per-frame target-colour bbox.
module vga_frame_monitor #(
  parameter int         H_ACTIVE        = 640,
  parameter int         H_FRONT         = 16,
  parameter int         H_SYNC          = 96,
  parameter int         H_BACK          = 48,
  parameter int         V_ACTIVE        = 480,
  parameter int         V_FRONT         = 10,
  parameter int         V_SYNC          = 2,
  parameter int         V_BACK          = 33,
  parameter int         SYNC_ACTIVE_LOW = 1,
  parameter logic [5:0] TARGET_RGB      = 6'b110000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vga_in,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_active,
  output logic [5:0] pix_rgb,
  output logic       locked,
  output logic       frame_done,
  output logic       bbox_valid,
  output logic [9:0] bbox_x0,
  output logic [9:0] bbox_x1,
  output logic [9:0] bbox_y0,
  output logic [9:0] bbox_y1,
  output logic [7:0] err_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  HT_M1  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  VT_M1  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  HOFF   = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0]  VOFF   = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]  HA     = 10'(H_ACTIVE);
  localparam logic [9:0]  VA     = 10'(V_ACTIVE);
  localparam logic [11:0] GAP_HT = 12'(H_TOTAL);
  localparam logic [11:0] GAP_TO = 12'(2 * H_TOTAL);
  localparam logic        SAL    = (SYNC_ACTIVE_LOW != 0);
  localparam logic [7:0]  IDLE   = {SAL, 3'b000, SAL, 3'b000};

  typedef enum logic [1:0] {
    UNLOCKED,
    HLOCK,
    LOCKED
  } state_t;

  state_t      state, state_n;
  logic [7:0]  s1;
  logic        hs1, vs1, hs2, vs2;
  logic        hs_edge, vs_edge;
  logic [5:0]  rgb1;
  logic [9:0]  h_inc, v_inc;
  logic        wrap;
  logic [11:0] gap;
  logic        v_seen;
  logic        h_bad, v_bad;
  logic        drop, eof, match;
  logic [9:0]  acc_x0, acc_x1;
  logic [9:0]  acc_y0, acc_y1;
  logic        hit;

  assign hs1     = s1[7] ^ SAL;
  assign vs1     = s1[3] ^ SAL;
  assign hs_edge = hs1 & ~hs2;
  assign vs_edge = vs1 & ~vs2;
  assign rgb1    = {s1[0], s1[4], s1[1],
                    s1[5], s1[2], s1[6]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= IDLE;
      hs2     <= 1'b0;
      vs2     <= 1'b0;
      pix_rgb <= 6'd0;
    end else begin
      s1      <= vga_in;
      hs2     <= hs1;
      vs2     <= vs1;
      pix_rgb <= rgb1;
    end
  end

  assign wrap  = !hs_edge && (pix_x == HT_M1);
  assign h_inc = (pix_x == HT_M1) ? 10'd0
                                  : pix_x + 10'd1;
  assign v_inc = !wrap ? pix_y
               : (pix_y == VT_M1) ? 10'd0
               : pix_y + 10'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_x <= 10'd0;
      pix_y <= 10'd0;
    end else begin
      pix_x <= hs_edge ? HOFF : h_inc;
      pix_y <= vs_edge ? VOFF : v_inc;
    end
  end

  // gap saturates high so the first edge never looks periodic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap <= 12'hFFF;
    end else if (hs_edge) begin
      gap <= 12'd1;
    end else if (gap != 12'hFFF) begin
      gap <= gap + 12'd1;
    end
  end

  assign h_bad = hs_edge && (h_inc != HOFF);
  assign v_bad = vs_edge && v_seen
              && (v_inc != VOFF);
  assign drop  = (state != UNLOCKED)
              && (h_bad || v_bad
                  || (!hs_edge && gap >= GAP_TO));

  always_comb begin
    state_n = state;
    unique case (state)
      UNLOCKED:
        if (hs_edge && gap == GAP_HT)
          state_n = HLOCK;
      HLOCK:
        if (drop)
          state_n = UNLOCKED;
        else if (vs_edge && v_seen)
          state_n = LOCKED;
      LOCKED:
        if (drop)
          state_n = UNLOCKED;
      default:
        state_n = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= UNLOCKED;
      v_seen    <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state <= state_n;
      if (state == UNLOCKED || drop)
        v_seen <= 1'b0;
      else if (vs_edge)
        v_seen <= 1'b1;
      if (drop && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

  assign locked     = (state == LOCKED);
  assign pix_active = locked
                   && (pix_x < HA)
                   && (pix_y < VA);

  assign eof   = locked && !drop && wrap
              && !vs_edge && (v_inc == VA);
  assign match = pix_active
              && (pix_rgb == TARGET_RGB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_x0     <= 10'h3FF;
      acc_x1     <= 10'd0;
      acc_y0     <= 10'h3FF;
      acc_y1     <= 10'd0;
      hit        <= 1'b0;
      frame_done <= 1'b0;
      bbox_valid <= 1'b0;
      bbox_x0    <= 10'd0;
      bbox_x1    <= 10'd0;
      bbox_y0    <= 10'd0;
      bbox_y1    <= 10'd0;
    end else begin
      frame_done <= eof;
      if (drop || eof) begin
        acc_x0 <= 10'h3FF;
        acc_x1 <= 10'd0;
        acc_y0 <= 10'h3FF;
        acc_y1 <= 10'd0;
        hit    <= 1'b0;
      end else if (match) begin
        if (pix_x < acc_x0) acc_x0 <= pix_x;
        if (pix_x > acc_x1) acc_x1 <= pix_x;
        if (pix_y < acc_y0) acc_y0 <= pix_y;
        if (pix_y > acc_y1) acc_y1 <= pix_y;
        hit <= 1'b1;
      end
      if (drop) begin
        bbox_valid <= 1'b0;
      end else if (eof) begin
        bbox_valid <= hit;
        if (hit) begin
          bbox_x0 <= acc_x0;
          bbox_x1 <= acc_x1;
          bbox_y0 <= acc_y0;
          bbox_y1 <= acc_y1;
        end
      end
    end
  end

endmodule
